// File: rtl/multiplier_arbiter_pkg.sv
// Shared definitions for the multiplier sequencing/sharing controller:
// FSM state encoding, requester count and counter width.
package multiplier_arbiter_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_NREQ  = 2;
  localparam int MUL_CNT_W = 4;

endpackage

// File: rtl/Multiplier.sv
// Combinational unsigned array multiplier; the product is exact (2*width bits).
module Multiplier #(
  parameter int width = 8
) (
  input  logic [width-1:0]   m,
  input  logic [width-1:0]   q,
  output logic [2*width-1:0] p
);

  // Assignment context widens both operands before the multiply.
  assign p = m * q;

endmodule

// File: rtl/mul_rr_grant.sv
// Two-input round-robin grant: a lone requester always wins, and a tie goes
// to the requester named by the pointer. Purely combinational.
module mul_rr_grant (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Arbitrates two requesters onto one Multiplier, holds the registered operands
// for LATENCY cycles (multicycle path) and returns the tagged product.
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int width   = 8,
  parameter int LATENCY = 2   // legal range 1..15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MUL_NREQ-1:0]       req_valid,
  output logic [MUL_NREQ-1:0]       req_ready,
  input  logic [MUL_NREQ*width-1:0] req_m,
  input  logic [MUL_NREQ*width-1:0] req_q,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [2*width-1:0]        rsp_product,
  output logic                      busy,
  output mul_state_e                dbg_state
);

  localparam logic [MUL_CNT_W-1:0] cnt_load = MUL_CNT_W'(LATENCY - 1);
  localparam logic [MUL_CNT_W-1:0] cnt_one  = MUL_CNT_W'(1);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high on the same channel; ready never depends on the opposite channel.
  mul_state_e             state, state_nxt;
  logic                   ptr;
  logic [MUL_CNT_W-1:0]   cnt;
  logic [width-1:0]       m_r, q_r;
  logic                   id_r;
  logic [MUL_NREQ-1:0]    grant;
  logic                   accept;
  logic                   acc_id;
  logic [2*width-1:0]     mul_p;

  mul_rr_grant u_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  Multiplier #(.width(width)) u_mul (
    .m (m_r),
    .q (q_r),
    .p (mul_p)
  );

  // rst_n gates ready so nothing is offered while reset is held.
  assign req_ready = (state == MUL_IDLE && rst_n) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = req_ready[1];
  assign rsp_valid = (state == MUL_DONE);
  assign busy      = (state != MUL_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (accept)         state_nxt = MUL_BUSY;
      MUL_BUSY: if (cnt == '0)      state_nxt = MUL_DONE;
      MUL_DONE: if (rsp_ready)      state_nxt = MUL_IDLE;
      default:                      state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      cnt         <= '0;
      m_r         <= '0;
      q_r         <= '0;
      id_r        <= 1'b0;
      rsp_product <= '0;
      rsp_id      <= 1'b0;
    end else begin
      if (state == MUL_IDLE && accept) begin
        m_r  <= acc_id ? req_m[2*width-1:width] : req_m[width-1:0];
        q_r  <= acc_id ? req_q[2*width-1:width] : req_q[width-1:0];
        id_r <= acc_id;
        ptr  <= ~acc_id;
        cnt  <= cnt_load;
      end
      // The product is sampled only once the operands have been static for
      // LATENCY cycles; m_r/q_r do not move until the next acceptance.
      if (state == MUL_BUSY) begin
        if (cnt == '0) begin
          rsp_product <= mul_p;
          rsp_id      <= id_r;
        end else begin
          cnt <= cnt - cnt_one;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Randomized bench for multiplier_arbiter at LATENCY=2 and LATENCY=1, checked
// against a transaction-level model (arbitration rule, timing, exact products).
module tb_multiplier_arbiter;

  logic        clk = 1'b0;
  logic        rst1_n, rst2_n;
  logic [1:0]  req_valid;
  logic [15:0] req_m, req_q;
  logic        rsp_ready;

  logic [1:0]  ready1, ready2;
  logic        vld1, vld2, id1, id2, busy1, busy2;
  logic [15:0] prod1, prod2;
  logic [1:0]  st1, st2;

  int sel;
  int lat;
  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          ptr_m;
  logic [7:0]  lane_m [2];
  logic [7:0]  lane_q [2];
  logic [16:0] exp_q [$];

  logic [1:0]  cur_ready;
  logic        cur_vld, cur_id, cur_busy;
  logic [15:0] cur_prod;
  logic [1:0]  cur_st;

  always #5 clk = ~clk;

  multiplier_arbiter #(.width(8), .LATENCY(2)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(req_valid), .req_ready(ready1),
    .req_m(req_m), .req_q(req_q), .rsp_valid(vld1), .rsp_ready(rsp_ready),
    .rsp_id(id1), .rsp_product(prod1), .busy(busy1), .dbg_state(st1)
  );

  multiplier_arbiter #(.width(8), .LATENCY(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req_valid(req_valid), .req_ready(ready2),
    .req_m(req_m), .req_q(req_q), .rsp_valid(vld2), .rsp_ready(rsp_ready),
    .rsp_id(id2), .rsp_product(prod2), .busy(busy2), .dbg_state(st2)
  );

  assign cur_ready = sel ? ready2 : ready1;
  assign cur_vld   = sel ? vld2   : vld1;
  assign cur_id    = sel ? id2    : id1;
  assign cur_busy  = sel ? busy2  : busy1;
  assign cur_prod  = sel ? prod2  : prod1;
  assign cur_st    = sel ? st2    : st1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h (L=%0d t=%0t)", tag, got, want, lat, $time);
    end
  endtask

  task automatic drive_lanes();
    req_m = {lane_m[1], lane_m[0]};
    req_q = {lane_q[1], lane_q[0]};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cur_ready, 2'b00);
    check({tag, "_vld"},   cur_vld,   1'b0);
    check({tag, "_busy"},  cur_busy,  1'b0);
    check({tag, "_id"},    cur_id,    1'b0);
    check({tag, "_prod"},  cur_prod,  16'd0);
    check({tag, "_state"}, cur_st,    2'd0);
  endtask

  // One request/response cycle: accept, LATENCY busy cycles, DONE held for
  // `hold` extra cycles with rsp_ready low, then the response handshake.
  task automatic run_txn(input logic [1:0] v, input int hold);
    int          w;
    logic [15:0] p;
    logic [16:0] e;
    @(negedge clk);
    req_valid = v;
    rsp_ready = (hold == 0);
    drive_lanes();
    #1;
    w = (v == 2'b11) ? ptr_m : ((v == 2'b10) ? 1 : 0);
    check("idle_busy",  cur_busy,  1'b0);
    check("idle_vld",   cur_vld,   1'b0);
    check("idle_state", cur_st,    2'd0);
    check("req_ready",  cur_ready, (w == 1) ? 2'b10 : 2'b01);
    p = lane_m[w] * lane_q[w];
    exp_q.push_back({w[0], p});
    ptr_m = 1 - w;

    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // winner may present fresh operands once accepted
        lane_m[w] = 8'($urandom_range(0, 255));
        lane_q[w] = 8'($urandom_range(0, 255));
        drive_lanes();
        #1;
      end
      check("busy_busy",  cur_busy,  1'b1);
      check("busy_vld",   cur_vld,   1'b0);
      check("busy_ready", cur_ready, 2'b00);
      check("busy_state", cur_st,    2'd1);
    end

    @(negedge clk);
    e = exp_q.pop_front();
    check("rsp_vld",   cur_vld,   1'b1);
    check("rsp_id",    cur_id,    e[16]);
    check("rsp_prod",  cur_prod,  e[15:0]);
    check("done_busy", cur_busy,  1'b1);
    check("done_rdy",  cur_ready, 2'b00);
    check("done_st",   cur_st,    2'd2);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_vld",   cur_vld,   1'b1);
      check("hold_id",    cur_id,    e[16]);
      check("hold_prod",  cur_prod,  e[15:0]);
      check("hold_busy",  cur_busy,  1'b1);
      check("hold_ready", cur_ready, 2'b00);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic set_rst(input logic val);
    if (sel == 0) rst1_n = val;
    else          rst2_n = val;
  endtask

  // Accept, then assert reset in the first BUSY cycle; nothing may come out.
  task automatic reset_midflight();
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    drive_lanes();
    #1;
    check("rm_ready", cur_ready, 2'b01);
    @(negedge clk);
    set_rst(1'b0);
    #1;
    check_reset_outputs("rm_rst");
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    set_rst(1'b1);
    ptr_m = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rm_no_rsp",  cur_vld,  1'b0);
      check("rm_no_busy", cur_busy, 1'b0);
    end
  endtask

  task automatic random_lanes();
    for (int k = 0; k < 2; k++) begin
      lane_m[k] = 8'($urandom_range(0, 255));
      lane_q[k] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    sel       = 0;
    lat       = 2;
    rst1_n    = 1'b0;
    rst2_n    = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    random_lanes();
    drive_lanes();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst1_n = 1'b1;
    req_valid = 2'b00;
    ptr_m = 0;

    lane_m[0] = 8'd13;  lane_q[0] = 8'd11;
    run_txn(2'b01, 0);
    lane_m[1] = 8'd255; lane_q[1] = 8'd255;
    run_txn(2'b10, 0);
    lane_m[0] = 8'd0;   lane_q[0] = 8'd200;
    run_txn(2'b01, 0);

    reset_midflight();
    for (int i = 0; i < 4; i++) begin
      random_lanes();
      run_txn(2'b11, 0);
    end
    run_txn(2'b11, 5);
    for (int i = 0; i < 20; i++) begin
      run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3));
    end
    reset_midflight();
    run_txn(2'b11, 0);

    // LATENCY=1 instance
    @(negedge clk);
    rst1_n    = 1'b0;
    req_valid = 2'b00;
    sel       = 1;
    lat       = 1;
    #1;
    check_reset_outputs("por2");
    rst2_n = 1'b1;
    ptr_m  = 0;
    for (int i = 0; i < 3; i++) run_txn(2'b01, 0);
    for (int i = 0; i < 10; i++) begin
      run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 2));
    end
    reset_midflight();
    run_txn(2'b11, 0);

    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
